// File: rtl/mm_bram_parallel_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mm_bram_parallel_ctrl_if
//  Brief    : Command, SRAM-read and datapath handshake bundle for the
//             parallel BRAM matrix-multiply sequencing controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface mm_bram_parallel_ctrl_if #(
    parameter int ROW_NUM = 32
) ();
    localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM);

    // Host command side
    logic                      start;
    logic [ROW_ADDR_WIDTH:0]   num_rows;
    logic                      stall;
    logic                      busy;
    logic                      done;
    logic                      ack_err;

    // Source SRAM read port
    logic                      src_rd_en;
    logic [ROW_ADDR_WIDTH-1:0] src_rdaddr;

    // Datapath row control and write acknowledge
    logic                      dpath_sum_en;
    logic [ROW_ADDR_WIDTH-1:0] dpath_result_wraddr;
    logic                      dpath_wr_ack;

    // Environment side: host, SRAM and datapath
    modport master (
        output start, num_rows, stall, dpath_wr_ack,
        input  src_rd_en, src_rdaddr, dpath_sum_en, dpath_result_wraddr,
               busy, done, ack_err
    );

    // Controller side
    modport slave (
        input  start, num_rows, stall, dpath_wr_ack,
        output src_rd_en, src_rdaddr, dpath_sum_en, dpath_result_wraddr,
               busy, done, ack_err
    );
endinterface
`default_nettype wire

// File: rtl/mm_bram_parallel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mm_bram_parallel_ctrl
//  Brief    : Issues row reads to the source SRAM, aligns row-valid/address
//             to the datapath through an SRAM_RD_LAT deep delay line, counts
//             result-write acks and pulses done when the job is complete.
//  Revision : 1.0 - initial release
// ============================================================================
module mm_bram_parallel_ctrl #(
    parameter int ROW_NUM     = 32,
    parameter int SRAM_RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    mm_bram_parallel_ctrl_if.slave bus
);
    localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM);
    localparam int CNT_WIDTH      = ROW_ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] c_row_num_max = CNT_WIDTH'(ROW_NUM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    logic [CNT_WIDTH-1:0]     r_n;
    logic [CNT_WIDTH-1:0]     r_issue_cnt;
    logic [CNT_WIDTH-1:0]     r_ack_cnt;
    logic                     r_busy;
    logic                     r_done;

    logic [SRAM_RD_LAT-1:0]   r_dly_vld;
    logic [ROW_ADDR_WIDTH-1:0] r_dly_addr [SRAM_RD_LAT];

    logic                     w_rd_en;
    logic [ROW_ADDR_WIDTH-1:0] w_rdaddr;
    logic                     w_ack_full;
    logic                     w_ack_inc;
    logic                     w_ack_err;
    logic [CNT_WIDTH-1:0]     w_issue_nxt;
    logic [CNT_WIDTH-1:0]     w_ack_nxt;
    logic [CNT_WIDTH-1:0]     w_n_clamped;

    // Reads are only issued while in ISSUE and the datapath is not stalling.
    assign w_rd_en     = (r_state == ISSUE) && !bus.stall;
    assign w_rdaddr    = r_issue_cnt[ROW_ADDR_WIDTH-1:0];
    assign w_issue_nxt = r_issue_cnt + CNT_WIDTH'(1);

    // An ack counts only in an active state and while rows remain unacked;
    // anything else is flagged as a protocol error in the same cycle.
    assign w_ack_full  = (r_ack_cnt == r_n);
    assign w_ack_inc   = bus.dpath_wr_ack && (r_state != IDLE) && !w_ack_full;
    assign w_ack_err   = bus.dpath_wr_ack && !w_ack_inc;
    assign w_ack_nxt   = w_ack_inc ? (r_ack_cnt + CNT_WIDTH'(1)) : r_ack_cnt;

    // Jobs larger than the SRAM depth are clamped so addresses never wrap.
    assign w_n_clamped = (bus.num_rows > c_row_num_max) ? c_row_num_max : bus.num_rows;

    // Job sequencing FSM with registered busy/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_n         <= '0;
            r_issue_cnt <= '0;
            r_ack_cnt   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_issue_cnt <= '0;
                    r_ack_cnt   <= '0;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    if (bus.start) begin
                        r_n    <= w_n_clamped;
                        r_busy <= 1'b1;
                        if (w_n_clamped == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_ack_cnt <= w_ack_nxt;
                    if (w_rd_en) begin
                        r_issue_cnt <= w_issue_nxt;
                        if (w_issue_nxt == r_n) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    r_ack_cnt <= w_ack_nxt;
                    if (w_ack_nxt == r_n) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_ack_cnt <= w_ack_nxt;
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Read-latency delay line: carries {valid, addr} so the datapath sees
    // the row strobe and result address together with the SRAM read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dly_vld <= '0;
            for (int i = 0; i < SRAM_RD_LAT; i++) begin
                r_dly_addr[i] <= '0;
            end
        end else begin
            r_dly_vld[0]  <= w_rd_en;
            r_dly_addr[0] <= w_rdaddr;
            for (int i = 1; i < SRAM_RD_LAT; i++) begin
                r_dly_vld[i]  <= r_dly_vld[i-1];
                r_dly_addr[i] <= r_dly_addr[i-1];
            end
        end
    end

    assign bus.src_rd_en           = w_rd_en;
    assign bus.src_rdaddr          = w_rdaddr;
    assign bus.dpath_sum_en        = r_dly_vld[SRAM_RD_LAT-1];
    assign bus.dpath_result_wraddr = r_dly_addr[SRAM_RD_LAT-1];
    assign bus.busy                = r_busy;
    assign bus.done                = r_done;
    assign bus.ack_err             = w_ack_err;

endmodule
`default_nettype wire

// File: tb/tb_mm_bram_parallel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mm_bram_parallel_ctrl
//  Brief    : Directed self-checking bench for mm_bram_parallel_ctrl.
//             Cycle k is the clock period that follows the edge at which the
//             job start was sampled (k = 1 is the first ISSUE cycle).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mm_bram_parallel_ctrl;
    localparam int ROW_NUM = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mm_bram_parallel_ctrl_if #(.ROW_NUM(ROW_NUM)) bus_a ();
    mm_bram_parallel_ctrl_if #(.ROW_NUM(ROW_NUM)) bus_b ();

    mm_bram_parallel_ctrl #(.ROW_NUM(ROW_NUM), .SRAM_RD_LAT(1)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    mm_bram_parallel_ctrl #(.ROW_NUM(ROW_NUM), .SRAM_RD_LAT(3)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int n_checks;
    int n_fails;
    int cyc;

    // Per-cycle stimulus masks (bit k applies during cycle k)
    logic [127:0] stall_mask;
    logic [127:0] start_mask;
    logic [127:0] reset_mask;
    logic [127:0] ack_mask;
    logic [5:0]   mid_num_rows;
    bit           auto_ack;
    logic [2:0]   hist_a;
    logic [2:0]   hist_b;

    // Per-DUT observation logs
    logic [127:0] rd_mask   [2];
    logic [127:0] sum_mask  [2];
    logic [127:0] busy_mask [2];
    logic [127:0] done_mask [2];
    logic [127:0] err_mask  [2];
    logic [14:0]  out_log   [2][128];
    int           rd_addr   [2][64];
    int           wr_addr   [2][64];
    int           rd_n      [2];
    int           wr_n      [2];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rng(input int lo, input int hi);
        logic [127:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic log_one(input int d, input logic rd, input logic [4:0] ra,
                           input logic se, input logic [4:0] wa,
                           input logic bz, input logic dn, input logic er);
        if (cyc < 128) begin
            rd_mask[d][cyc]   = rd;
            sum_mask[d][cyc]  = se;
            busy_mask[d][cyc] = bz;
            done_mask[d][cyc] = dn;
            err_mask[d][cyc]  = er;
            out_log[d][cyc]   = {rd, ra, se, wa, bz, dn, er};
        end
        if (rd && rd_n[d] < 64) begin
            rd_addr[d][rd_n[d]] = int'(ra);
            rd_n[d]++;
        end
        if (se && wr_n[d] < 64) begin
            wr_addr[d][wr_n[d]] = int'(wa);
            wr_n[d]++;
        end
    endtask

    task automatic clear_stim();
        stall_mask   = '0;
        start_mask   = '0;
        reset_mask   = '0;
        ack_mask     = '0;
        mid_num_rows = '0;
        auto_ack     = 1'b1;
    endtask

    // Advance one cycle: drive this cycle's inputs after the edge, then sample.
    task automatic tick();
        int ci;
        @(posedge clk);
        #1;
        cyc++;
        ci = (cyc < 128) ? cyc : 127;
        reset        = reset_mask[ci];
        bus_a.stall  = stall_mask[ci];
        bus_b.stall  = stall_mask[ci];
        bus_a.start  = start_mask[ci];
        bus_b.start  = 1'b0;
        if (start_mask[ci]) bus_a.num_rows = mid_num_rows;
        bus_a.dpath_wr_ack = (auto_ack && hist_a[2]) || ack_mask[ci];
        bus_b.dpath_wr_ack = auto_ack && hist_b[2];
        #1;
        log_one(0, bus_a.src_rd_en, bus_a.src_rdaddr, bus_a.dpath_sum_en,
                bus_a.dpath_result_wraddr, bus_a.busy, bus_a.done, bus_a.ack_err);
        log_one(1, bus_b.src_rd_en, bus_b.src_rdaddr, bus_b.dpath_sum_en,
                bus_b.dpath_result_wraddr, bus_b.busy, bus_b.done, bus_b.ack_err);
        hist_a = {hist_a[1:0], bus_a.dpath_sum_en};
        hist_b = {hist_b[1:0], bus_b.dpath_sum_en};
    endtask

    task automatic run(input int ncyc);
        for (int i = 0; i < ncyc; i++) tick();
    endtask

    // Called in cycle 0: start is held up to the edge that ends cycle 0.
    task automatic begin_job(input int d, input int nrows);
        for (int k = 0; k < 2; k++) begin
            rd_mask[k] = '0; sum_mask[k] = '0; busy_mask[k] = '0;
            done_mask[k] = '0; err_mask[k] = '0;
            rd_n[k] = 0; wr_n[k] = 0;
            for (int j = 0; j < 64; j++) begin
                rd_addr[k][j] = -1;
                wr_addr[k][j] = -1;
            end
        end
        hist_a = '0;
        hist_b = '0;
        cyc    = 0;
        if (d == 0) begin
            bus_a.num_rows = 6'(nrows);
            bus_a.start    = 1'b1;
        end else begin
            bus_b.num_rows = 6'(nrows);
            bus_b.start    = 1'b1;
        end
    endtask

    task automatic check_job(input string tag, input int d,
                             input logic [127:0] e_rd, input logic [127:0] e_sum,
                             input logic [127:0] e_busy, input logic [127:0] e_done,
                             input logic [127:0] e_err, input int e_rd_n, input int e_wr_n);
        check_eq({tag, " rd_en cycles"}, rd_mask[d], e_rd);
        check_eq({tag, " sum_en cycles"}, sum_mask[d], e_sum);
        check_eq({tag, " busy cycles"}, busy_mask[d], e_busy);
        check_eq({tag, " done cycles"}, done_mask[d], e_done);
        check_eq({tag, " ack_err cycles"}, err_mask[d], e_err);
        check_eq({tag, " read count"}, rd_n[d], e_rd_n);
        check_eq({tag, " row count"}, wr_n[d], e_wr_n);
        for (int k = 0; k < e_rd_n && k < 64; k++)
            check_eq($sformatf("%s rdaddr%0d", tag, k), rd_addr[d][k], k);
        for (int k = 0; k < e_wr_n && k < 64; k++)
            check_eq($sformatf("%s wraddr%0d", tag, k), wr_addr[d][k], k);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        cyc      = 0;
        clear_stim();
        hist_a = '0;
        hist_b = '0;
        reset  = 1'b1;
        bus_a.start = 1'b0; bus_a.num_rows = '0; bus_a.stall = 1'b0; bus_a.dpath_wr_ack = 1'b0;
        bus_b.start = 1'b0; bus_b.num_rows = '0; bus_b.stall = 1'b0; bus_b.dpath_wr_ack = 1'b0;

        // Reset state: every output low
        repeat (3) @(posedge clk);
        #2;
        check_eq("reset outputs A", {bus_a.src_rd_en, bus_a.src_rdaddr, bus_a.dpath_sum_en,
                 bus_a.dpath_result_wraddr, bus_a.busy, bus_a.done, bus_a.ack_err}, '0);
        check_eq("reset outputs B", {bus_b.src_rd_en, bus_b.src_rdaddr, bus_b.dpath_sum_en,
                 bus_b.dpath_result_wraddr, bus_b.busy, bus_b.done, bus_b.ack_err}, '0);
        reset = 1'b0;
        run(2);

        // Basic 4-row job, acks 3 cycles after each row strobe
        clear_stim();
        begin_job(0, 4);
        run(12);
        check_job("basic", 0, rng(1,4), rng(2,5), rng(1,9), rng(9,9), '0, 4, 4);

        // Stall in cycles 2-3 holds off the second read
        clear_stim();
        stall_mask = rng(2,3);
        begin_job(0, 3);
        run(14);
        check_job("stall", 0, rng(1,1) | rng(4,5), rng(2,2) | rng(5,6),
                  rng(1,10), rng(10,10), '0, 3, 3);

        // Zero-row job goes straight to DONE
        clear_stim();
        begin_job(0, 0);
        run(4);
        check_job("zero", 0, '0, '0, rng(1,1), rng(1,1), '0, 0, 0);

        // Oversized job clamps to ROW_NUM rows
        clear_stim();
        begin_job(0, 40);
        run(42);
        check_job("clamp", 0, rng(1,32), rng(2,33), rng(1,37), rng(37,37), '0, 32, 32);

        // Ack protocol: two acks fill the count, a third is an error and is
        // not counted (DRAIN must still see ack_cnt == n); an IDLE ack errors
        clear_stim();
        auto_ack   = 1'b0;
        stall_mask = rng(1,5);
        ack_mask   = rng(1,3) | rng(11,11);
        begin_job(0, 2);
        run(13);
        check_job("ackproto", 0, rng(6,7), rng(7,8), rng(1,9), rng(9,9),
                  rng(3,3) | rng(11,11), 2, 2);

        // Start during ISSUE with a new num_rows is ignored
        clear_stim();
        start_mask   = rng(2,2);
        mid_num_rows = 6'd10;
        begin_job(0, 3);
        run(14);
        check_job("ignstart", 0, rng(1,3), rng(2,4), rng(1,8), rng(8,8), '0, 3, 3);

        // Reset during ISSUE of an 8-row job discards in-flight rows
        clear_stim();
        auto_ack   = 1'b0;
        reset_mask = rng(3,3);
        begin_job(0, 8);
        run(8);
        check_eq("midreset outputs cycle4", out_log[0][4], '0);
        check_job("midreset", 0, rng(1,3), rng(2,3), rng(1,3), '0, '0, 3, 2);

        // A fresh job after the mid-job reset completes normally
        clear_stim();
        begin_job(0, 2);
        run(10);
        check_job("postreset", 0, rng(1,2), rng(2,3), rng(1,7), rng(7,7), '0, 2, 2);

        // Read latency 3: every row strobe lags its read by exactly 3 cycles
        clear_stim();
        begin_job(1, 5);
        run(15);
        check_job("lat3", 1, rng(1,5), rng(4,8), rng(1,12), rng(12,12), '0, 5, 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mm_bram_parallel_ctrl.md
# mm_bram_parallel_ctrl

Sequencing controller for the parallel BRAM matrix-multiply datapath. On a start pulse it streams a programmable number of row addresses into the source SRAM and drives the datapath's `dpath_sum_en` / `dpath_result_wraddr` in step with the SRAM read latency. It counts result-row write acknowledgements returning from the datapath and raises a one-cycle `done` once every issued row has been written to the result SRAM. It sits between the top-level host/command logic and the source SRAM and datapath.

## Interface

Parameters:
- `ROW_NUM`, 32: maximum rows per job; also the source and result SRAM depth.
- `SRAM_RD_LAT`, 1: source SRAM read latency in cycles, ≥ 1.
- `ROW_ADDR_WIDTH`, `$clog2(ROW_NUM)`: derived; not set manually.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: job start pulse. Sampled only in IDLE.
- `num_rows`, in, ROW_ADDR_WIDTH+1: rows in the job. Latched on an accepted start.
- `stall`, in, 1: while high, no new row is issued.
- `src_rd_en`, out, 1: source SRAM read enable.
- `src_rdaddr`, out, ROW_ADDR_WIDTH: source SRAM read address.
- `dpath_sum_en`, out, 1: row-valid to the datapath, aligned with SRAM read data.
- `dpath_result_wraddr`, out, ROW_ADDR_WIDTH: result row address to the datapath, aligned with `dpath_sum_en`.
- `dpath_wr_ack`, in, 1: datapath result-write strobe. Connect to column 0 of the datapath's `row_wr_en`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle job-complete pulse.
- `ack_err`, out, 1: one-cycle pulse when an unexpected ack arrives.

## Operation

- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `n = min(num_rows, ROW_NUM)`.
  - Clears `issue_cnt` and `ack_cnt`.
  - Next state is ISSUE if n>0, otherwise DONE.
- ISSUE:
  - `src_rd_en = !stall`, combinational from the state register and `stall`.
  - `src_rdaddr = issue_cnt`, which is a register.
  - Each cycle with `src_rd_en`=1 increments `issue_cnt`.
  - When the issue that makes `issue_cnt == n` occurs, the next state is DRAIN.
- Delay line:
  - SRAM_RD_LAT register stages carry {valid, addr}.
  - Stage input is {`src_rd_en`, `src_rdaddr`}.
  - The last stage drives `dpath_sum_en` and `dpath_result_wraddr`.
  - The delay line runs in all states and is cleared only by reset.
- Ack counting:
  - In ISSUE, DRAIN and DONE, each `dpath_wr_ack` increments `ack_cnt` (width ROW_ADDR_WIDTH+1).
  - An ack that arrives when `ack_cnt == n`, or any ack in IDLE, does not count and pulses `ack_err` in the same cycle.
- DRAIN: when `ack_cnt == n` (including an ack counted this cycle), the next state is DONE.
- DONE: `done`=1 for exactly this one cycle, then the next state is IDLE.
- `start` outside IDLE is ignored. It does not queue.
- `num_rows` and `stall` changes during a job do not affect the latched `n`. `stall` only gates issue.

## Timing

- Reset values:
  - state = IDLE.
  - `issue_cnt` = 0, `ack_cnt` = 0, and all delay stages are 0.
  - Outputs: `src_rd_en`=0, `src_rdaddr`=0, `dpath_sum_en`=0, `dpath_result_wraddr`=0, `busy`=0, `done`=0, `ack_err`=0.
- Reset mid-job returns the block to IDLE next cycle with all of the above cleared. In-flight delay-line entries are discarded.
- Start to first read: `start` sampled at edge 0 gives ISSUE in cycle 1, so the first `src_rd_en` is in cycle 1 if `stall`=0.
- Read to datapath: `dpath_sum_en` for address a is asserted exactly SRAM_RD_LAT cycles after the `src_rd_en` for a.
- Issue rate: with no stall, n reads occur on consecutive cycles 1..n, and DRAIN starts in cycle n+1.
- Completion: `done` is asserted the cycle after the edge at which the n-th ack is counted.
- n=0: `start` at edge 0 gives DONE in cycle 1 with `done`=1, and IDLE in cycle 2. No reads are issued.
- The earliest accepted back-to-back start is in the cycle after `done`, i.e. in IDLE.
- Addresses never wrap: the maximum issued address is n−1 ≤ ROW_NUM−1.

## Test plan

- Basic job: ROW_NUM=32, SRAM_RD_LAT=1, `num_rows`=4, no stall, acks returned 3 cycles after each `dpath_sum_en`.
  - Reads at cycles 1–4 with addr 0–3.
  - `dpath_sum_en` at cycles 2–5 with wraddr 0–3.
  - `done` at cycle 9; `busy` high over cycles 1–9.
- Stall: `num_rows`=3 with `stall`=1 in cycles 2–3.
  - Addr 0 issued at cycle 1, addr 1 at cycle 4, addr 2 at cycle 5.
  - No `src_rd_en` during the stall cycles.
- Edge sizes:
  - `num_rows`=0: `done` at cycle 1, no `src_rd_en` ever.
  - `num_rows`=40: clamps to 32, so addresses 0–31 are issued and `done` follows the 32nd ack.
- Ack protocol:
  - An extra ack after the n-th ack pulses `ack_err` and leaves `ack_cnt` = n.
  - An ack while IDLE pulses `ack_err`.
  - Ignored start: `start` during ISSUE does not restart the job or change n.
- Reset mid-job: assert `reset` during ISSUE of a `num_rows`=8 job.
  - Next cycle: all outputs 0, state IDLE, delay line empty, so no stale `dpath_sum_en`.
  - A new `num_rows`=2 job then completes normally.
- Latency sweep: SRAM_RD_LAT=3, `num_rows`=5. `dpath_sum_en` and wraddr lag `src_rd_en` and rdaddr by exactly 3 cycles for every row.
